// File: rtl/ktane_bus_pkg.sv
// Shared definitions for the ktane bus arbiter and the ktane_mem memory map.
// Contents:
//   region_t      - 3-bit memory-map window code
//   *_BASE        - first address of each window above RAM
//   state_t       - arbiter sequencer states
//   is_legal()    - access permission of a window for a read or a write
package ktane_bus_pkg;

    typedef enum logic [2:0] {
        REG_RAM    = 3'd0,
        REG_BUTTON = 3'd1,
        REG_KEYPAD = 3'd2,
        REG_MORSE  = 3'd3,
        REG_WIRES  = 3'd4,
        REG_EXTRAS = 3'd5,
        REG_NONE   = 3'd6
    } region_t;

    localparam logic [15:0] BUTTON_BASE = 16'hC000;
    localparam logic [15:0] KEYPAD_BASE = 16'hCCCC;
    localparam logic [15:0] MORSE_BASE  = 16'hD998;
    localparam logic [15:0] WIRES_BASE  = 16'hE664;
    localparam logic [15:0] EXTRAS_BASE = 16'hF330;
    localparam logic [15:0] NONE_BASE   = 16'hFFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // MORSE only accepts writes, WIRES only serves reads, NONE maps nothing.
    function automatic logic is_legal(input region_t region, input logic we);
        case (region)
            REG_NONE:  return 1'b0;
            REG_MORSE: return we;
            REG_WIRES: return !we;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ktane_region_decode.sv
// Combinational address-to-window decoder for the ktane memory map.
// Ports:
//   addr   in   ADDR_WIDTH  bus address
//   region out  region_t    window the address falls in
// Addresses beyond 16 bits (when ADDR_WIDTH > 16) decode to REG_NONE.
module ktane_region_decode
    import ktane_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output region_t               region
);

    logic [31:0] a;

    assign a = 32'(addr);

    always_comb begin
        if (a < 32'(BUTTON_BASE))
            region = REG_RAM;
        else if (a < 32'(KEYPAD_BASE))
            region = REG_BUTTON;
        else if (a < 32'(MORSE_BASE))
            region = REG_KEYPAD;
        else if (a < 32'(WIRES_BASE))
            region = REG_MORSE;
        else if (a < 32'(EXTRAS_BASE))
            region = REG_WIRES;
        else if (a < 32'(NONE_BASE))
            region = REG_EXTRAS;
        else
            region = REG_NONE;
    end

endmodule

// File: rtl/ktane_bus_arb.sv
// Two-requester round-robin arbiter and transaction sequencer in front of the
// single-port ktane_mem memory map. Requester 0 is the CPU, requester 1 the
// game sequencer.
// Ports:
//   clk, reset                  clock, async active-high reset
//   req*/we*/addr*/wdata*       requester side, req held until its ack
//   ack0, ack1, err, rdata      one-cycle completion, reject flag, read data
//   busy                        transaction in progress
//   mem_*                       ktane_mem port (data, addresses, we, re, q)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate and latch the winner's request
// ST_ISSUE | one cycle: drive address plus mem_we or mem_re
// ST_WAIT  | read only: count down the memory latency, capture mem_q at 0
// ST_DONE  | one cycle: ack the owner, err for rejected accesses
module ktane_bus_arb
    import ktane_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    READ_LAT   = 2,
    parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR  = ADDR_WIDTH'(16'hFFFC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t                state, state_nxt;
    logic                  owner;
    logic                  rr_ptr;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    region_t               lat_region;
    logic                  lat_rej;
    logic [CNT_W-1:0]      cnt;

    logic                  gnt_any;
    logic                  gnt_sel;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    region_t               sel_region;
    logic                  sel_legal;

    // A lone requester wins outright; a tie goes to rr_ptr.
    assign gnt_any   = req0 | req1;
    assign gnt_sel   = (req0 && req1) ? rr_ptr : req1;
    assign sel_we    = gnt_sel ? we1    : we0;
    assign sel_addr  = gnt_sel ? addr1  : addr0;
    assign sel_wdata = gnt_sel ? wdata1 : wdata0;

    ktane_region_decode #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .addr   (sel_addr),
        .region (sel_region)
    );

    assign sel_legal = is_legal(sel_region, sel_we);
    assign lat_rej   = !is_legal(lat_region, lat_we);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            rr_ptr     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= IDLE_ADDR;
            lat_wdata  <= '0;
            lat_region <= REG_NONE;
            cnt        <= '0;
            rdata      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        owner      <= gnt_sel;
                        rr_ptr     <= !gnt_sel;
                        lat_we     <= sel_we;
                        lat_addr   <= sel_addr;
                        lat_wdata  <= sel_wdata;
                        lat_region <= sel_region;
                        // Rejected accesses jump straight to DONE with zero data.
                        if (!sel_legal)
                            rdata <= '0;
                    end
                end
                ST_ISSUE: cnt <= CNT_W'(READ_LAT - 1);
                ST_WAIT: begin
                    if (cnt == '0)
                        rdata <= mem_q;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b0;
        ack0           = 1'b0;
        ack1           = 1'b0;
        err            = 1'b0;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        mem_data       = '0;
        mem_write_addr = IDLE_ADDR;
        mem_read_addr  = IDLE_ADDR;
        case (state)
            ST_IDLE: begin
                if (gnt_any)
                    state_nxt = sel_legal ? ST_ISSUE : ST_DONE;
            end
            ST_ISSUE: begin
                busy           = 1'b1;
                mem_write_addr = lat_addr;
                mem_read_addr  = lat_addr;
                if (lat_we) begin
                    mem_we    = 1'b1;
                    mem_data  = lat_wdata;
                    state_nxt = ST_DONE;
                end else begin
                    mem_re    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy           = 1'b1;
                mem_write_addr = lat_addr;
                mem_read_addr  = lat_addr;
                if (cnt == '0)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                ack0      = !owner;
                ack1      = owner;
                err       = lat_rej;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
